reg_dump_unit: RTL

Debug read-out engine for the RV32I register file. On request it stalls the core, walks one register-file read port across every architectural register, and streams each value with its index over a valid/ready interface. It sits beside the core's register file, borrows the port's address input during a dump, and feeds a debug/trace transport.

---
 rtl/reg_dump_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/reg_dump_unit.sv
// rtl/reg_dump_unit.sv - halts the core and streams every RV32I register with its index
module reg_dump_unit #(
    parameter bit SKIP_X0 = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_READ,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [4:0] FIRST_IDX = SKIP_X0 ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_IDX  = 5'd31;

    state_e      state_q,     state_d;
    logic [4:0]  idx_q,       idx_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q,  out_data_d;
    logic [4:0]  out_index_q, out_index_d;
    logic        out_last_q,  out_last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_index_q <= 5'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = S_HALT_WAIT;
                end
            end
            S_HALT_WAIT: begin
                if (halt_ack) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // rf_data is combinational from rf_addr, so it is only sampled here
                out_data_d  = rf_data;
                out_index_d = idx_q;
                out_last_d  = (idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign halt_req  = (state_q == S_HALT_WAIT) || (state_q == S_READ) || (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rf_addr   = (state_q == S_IDLE) ? 5'd0 : idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule
